// File: rtl/uart_pkg.sv
// uart_pkg: constants, states and frame helpers shared by the UART receive and transmit engines.
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int BAUD_W = 19;
  typedef enum logic {IDLE, SEND} tx_state_e;
  function automatic logic uart_parity(input logic [7:0] data, input logic eight, input logic ohel);
    return ^(eight ? data : {1'b0, data[6:0]}) ^ ohel;
  endfunction
  // Bit 0 is the start bit; bits 8..10 carry D7/parity/stop depending on format.
  function automatic logic [FRAME_BITS-1:0] uart_frame(input logic eight, input logic pen, input logic ohel, input logic [7:0] data);
    logic p, b8, b9;
    p = uart_parity(data, eight, ohel);
    b8 = eight ? data[7] : (pen ? p : 1'b1);
    b9 = (eight && pen) ? p : 1'b1;
    return {1'b1, b9, b8, data[6:0], 1'b0};
  endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-time counter plus bit counter; the receiver preloads a half bit.
module uart_bit_timer #(
  parameter int BAUD_W = uart_pkg::BAUD_W,
  parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              run_i,
  input  logic [BAUD_W-1:0] baud_i,
  input  logic [BAUD_W-1:0] preload_i,
  output logic              bit_done_o,
  output logic              frame_done_o
);
  localparam int BW = $clog2(FRAME_BITS);
  logic [BAUD_W-1:0] cnt_q, cnt_d, last;
  logic [BW-1:0] bits_q, bits_d;
  // A divisor of 0 behaves like 1: every clock is a full bit time.
  assign last = (baud_i > BAUD_W'(1)) ? baud_i - BAUD_W'(1) : '0;
  assign bit_done_o = run_i && (cnt_q == last);
  assign frame_done_o = bit_done_o && (bits_q == BW'(FRAME_BITS - 1));
  always_comb begin
    cnt_d = load_i ? preload_i : bit_done_o ? '0 : run_i ? cnt_q + BAUD_W'(1) : cnt_q;
    bits_d = (load_i || frame_done_o) ? '0 : bit_done_o ? bits_q + BW'(1) : bits_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      bits_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      bits_q <= bits_d;
    end
  end
endmodule

// File: rtl/tx_engine.sv
// tx_engine: UART transmitter; serialises one 11-bit-time frame per LOAD onto TX.
module tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_W = uart_pkg::BAUD_W,
  parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BAUD_W-1:0] BAUD_DECODE,
  input  logic              EIGHT,
  input  logic              PEN,
  input  logic              OHEL,
  input  logic              LOAD,
  input  logic [7:0]        OUT_PORT,
  output logic              TX,
  output logic              TX_RDY,
  output logic              TX_DONE
);
  tx_state_e state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic done_q, done_d, start, bit_done, frame_done;
  uart_bit_timer #(.BAUD_W(BAUD_W), .FRAME_BITS(FRAME_BITS)) u_timer (
    .clk(clk),
    .rst_n(rst),
    .load_i(start),
    .run_i(state_q == SEND),
    .baud_i(baud_q),
    .preload_i('0),
    .bit_done_o(bit_done),
    .frame_done_o(frame_done)
  );
  // Format bits are folded into the shift register at load, so later config changes cannot reach the frame.
  always_comb begin
    state_d = state_q;
    baud_d = baud_q;
    sh_d = sh_q;
    done_d = 1'b0;
    start = 1'b0;
    if (state_q == IDLE && LOAD) begin
      state_d = SEND;
      baud_d = BAUD_DECODE;
      sh_d = uart_frame(EIGHT, PEN, OHEL, OUT_PORT);
      start = 1'b1;
    end else if (state_q == SEND && bit_done) begin
      sh_d = {1'b1, sh_q[FRAME_BITS-1:1]};
      state_d = frame_done ? IDLE : SEND;
      done_d = frame_done;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      sh_q <= '1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      sh_q <= sh_d;
      done_q <= done_d;
    end
  end
  assign TX = sh_q[0];
  assign TX_RDY = (state_q == IDLE);
  assign TX_DONE = done_q;
endmodule
